// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared constants and state encoding for the fetch-side PC sequencer.
// Exports INSTR_W, default vectors and the sequencer state type.
package pc_fetch_sequencer_pkg;

  localparam int INSTR_W = 32;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_BOOT = S_BOOT,
    ST_REQ  = S_REQ,
    ST_HOLD = S_HOLD
  } state_t;

endpackage

// File: rtl/pc_redirect_mux.sv
// Priority redirect select: exception > branch > jump, word-aligned target.
// In: exception/branch/jump requests+targets. Out: any_redirect, is_exc, target.
module pc_redirect_mux
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic              exception,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              any_redirect,
  output logic              is_exc,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] raw;

  always_comb begin
    raw = '0;
    if (exception)
      raw = EXC_VECTOR;
    else if (branch_taken)
      raw = branch_target;
    else if (jump)
      raw = jump_target;
  end

  assign target       = {raw[ADDR_W-1:2], 2'b00};
  assign any_redirect = exception | branch_taken | jump;
  assign is_exc       = exception;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch PC owner: sequences imem req/ack, squashes stale fetches, holds on stall.
// Ports: imem req/addr/ack/rdata, redirects, stall, instr out to IF/ID, pc_next/pc_write.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(EXC_VECTOR_DEF)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               exception,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_write
);

  state_t             state;
  logic [ADDR_W-1:0]  cur_pc;
  logic [ADDR_W-1:0]  pend_pc;
  logic               pend_valid;
  logic               pend_exc;
  logic [ADDR_W-1:0]  hold_pc;
  logic [INSTR_W-1:0] hold_instr;

  logic              redir;
  logic              redir_exc;
  logic [ADDR_W-1:0] redir_pc;

  pc_redirect_mux #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect (
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .any_redirect  (redir),
    .is_exc        (redir_exc),
    .target        (redir_pc)
  );

  logic in_boot;
  logic in_req;
  logic in_hold;
  logic drop;
  logic pass;
  logic hold_out;
  logic keep_pend;
  logic [ADDR_W-1:0] seq_pc;

  assign in_boot = (state == ST_BOOT);
  assign in_req  = (state == ST_REQ);
  assign in_hold = (state == ST_HOLD);
  assign seq_pc  = cur_pc + ADDR_W'(4);

  // Returned data is stale if any redirect is live now or was seen
  // while the request was outstanding.
  assign drop     = redir | pend_valid;
  assign pass     = in_req & imem_ack & ~drop & ~stall;
  assign hold_out = in_hold & ~redir;

  // Only an exception may replace a pending exception.
  assign keep_pend = pend_valid & pend_exc & ~redir_exc;

  assign imem_req  = in_req;
  assign imem_addr = cur_pc;

  assign instr_valid = pass | hold_out;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (pass) begin
      instr    = imem_rdata;
      instr_pc = cur_pc;
    end else if (hold_out) begin
      instr    = hold_instr;
      instr_pc = hold_pc;
    end
  end

  always_comb begin
    pc_next = cur_pc;
    unique case (1'b1)
      in_boot: begin
        if (redir)
          pc_next = redir_pc;
      end
      in_req: begin
        if (imem_ack) begin
          if (redir)
            pc_next = redir_pc;
          else if (pend_valid)
            pc_next = pend_pc;
          else
            pc_next = seq_pc;
        end
      end
      in_hold: begin
        if (redir)
          pc_next = redir_pc;
      end
      default: pc_next = cur_pc;
    endcase
  end

  assign pc_write = (pc_next != cur_pc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_BOOT;
      cur_pc     <= RESET_VECTOR;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      pend_exc   <= 1'b0;
      hold_pc    <= '0;
      hold_instr <= '0;
    end else begin
      cur_pc <= pc_next;
      unique case (state)
        ST_BOOT: state <= ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
            if (!drop && stall) begin
              hold_instr <= imem_rdata;
              hold_pc    <= cur_pc;
              state      <= ST_HOLD;
            end
          end else if (redir && !keep_pend) begin
            pend_valid <= 1'b1;
            pend_pc    <= redir_pc;
            pend_exc   <= redir_exc;
          end
        end
        ST_HOLD: begin
          if (redir || !stall)
            state <= ST_REQ;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: fetch-stream model plus
// directed scenarios with literal expectations.
module tb_pc_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        exception = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_next;
  logic        pc_write;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int cnt = 0;

  always #5 clock = ~clock;

  pc_fetch_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .pc_next       (pc_next),
    .pc_write      (pc_write)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Memory: ack after `lat` extra wait cycles; only while req is high.
  assign imem_ack   = imem_req && (cnt >= lat);
  assign imem_rdata = mem(imem_addr);

  always @(posedge clock)
    cnt <= (!imem_req || imem_ack) ? 0 : cnt + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream model: next PC that must be delivered, with a sticky
  // exception while a fetch is outstanding.
  logic [31:0] exp_pc = '0;
  logic [31:0] t;
  bit          sticky = 0;
  bit          p_ok = 0;
  bit          p_pend = 0;
  bit          p_req = 0;
  bit          p_wr = 0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_next = '0;
  bit          redir;

  always @(negedge clock) begin
    if (!reset) begin
      exp_pc = 32'h0;
      sticky = 0;
      p_ok   = 0;
    end else begin
      redir = exception | branch_taken | jump;
      if (instr_valid) begin
        chk("stream_pc", instr_pc, exp_pc);
        chk("stream_instr", instr, mem(exp_pc));
      end
      if (redir)
        chk("drop_on_redirect", 32'(instr_valid), 32'd0);
      if (p_ok && p_pend) begin
        chk("req_stable", 32'(imem_req), 32'd1);
        chk("addr_stable", imem_addr, p_addr);
      end
      if (p_ok && imem_req)
        chk("pc_next_taken", imem_addr, p_next);
      if (p_ok && p_req && imem_req)
        chk("pc_write_flag", 32'(p_wr), 32'(p_next != p_addr));
      if (redir) begin
        if (exception)         t = 32'h80;
        else if (branch_taken) t = branch_target & ~32'h3;
        else                   t = jump_target & ~32'h3;
        if (!(sticky && !exception && !imem_ack))
          exp_pc = t;
        if (exception && imem_req && !imem_ack)
          sticky = 1;
      end else if (instr_valid && !stall) begin
        exp_pc = exp_pc + 32'h4;
      end
      if (imem_ack)
        sticky = 0;
      p_ok   = 1;
      p_pend = imem_req && !imem_ack;
      p_addr = imem_addr;
      p_next = pc_next;
      p_req  = imem_req;
      p_wr   = pc_write;
    end
  end

  task automatic do_reset(input int l);
    reset = 1'b0;
    stall = 1'b0;
    exception = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    lat = l;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      hit = imem_req && (imem_addr == a);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_addr: no request for %h, required within 200", a);
    end
  endtask

  task automatic next_addr(input logic [31:0] old,
                           output logic [31:0] a);
    bit hit = 0;
    a = 'x;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      hit = imem_req && (imem_addr != old);
      if (hit) a = imem_addr;
    end
  endtask

  task automatic next_valid(output logic [31:0] pc);
    bit hit = 0;
    pc = 'x;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      hit = instr_valid;
      if (hit) pc = instr_pc;
    end
  endtask

  logic [31:0] a;
  int n4;
  int nv;

  initial begin
    // Reset values, then zero-wait streaming.
    repeat (2) @(negedge clock);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_pc_next", pc_next, 32'h0);
    #1 reset = 1'b1;
    #1 chk("boot_idle", 32'(imem_req), 32'd0);
    @(negedge clock);
    chk("s1_req", 32'(imem_req), 32'd1);
    chk("s1_valid0", 32'(instr_valid), 32'd1);
    chk("s1_pc0", instr_pc, 32'h0);
    chk("s1_instr0", instr, 32'h1000_0000);
    @(negedge clock);
    chk("s1_pc4", instr_pc, 32'h4);
    @(negedge clock);
    chk("s1_pc8", instr_pc, 32'h8);
    chk("s1_instr8", instr, 32'h1000_0008);

    // Three-cycle memory.
    do_reset(2);
    n4 = 0;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (imem_req && imem_addr == 32'h4) n4++;
      if (instr_valid) nv++;
    end
    chk("s2_addr4_cycles", 32'(n4), 32'd3);
    chk("s2_valid_pulses", 32'(nv), 32'd4);

    // Branch while waiting on 0x8.
    do_reset(2);
    wait_addr(32'h8);
    @(posedge clock);
    #1 branch_taken = 1'b1;
    branch_target = 32'h2001;
    @(posedge clock);
    #1 branch_taken = 1'b0;
    next_addr(32'h8, a);
    chk("s3_next_addr", a, 32'h2000);
    next_valid(a);
    chk("s3_first_pc", a, 32'h2000);

    // Exception+jump, then branch while still waiting.
    do_reset(3);
    wait_addr(32'h4);
    @(posedge clock);
    #1 exception = 1'b1;
    jump = 1'b1;
    jump_target = 32'h400;
    @(posedge clock);
    #1 exception = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b1;
    branch_target = 32'h3000;
    @(posedge clock);
    #1 branch_taken = 1'b0;
    next_addr(32'h4, a);
    chk("s4_next_addr", a, 32'h80);
    next_valid(a);
    chk("s4_first_pc", a, 32'h80);

    // Stall on ack of 0xC.
    do_reset(1);
    wait_addr(32'hC);
    @(posedge clock);
    #1 stall = 1'b1;
    @(negedge clock);
    chk("s5_capture_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("s5_hold_valid", 32'(instr_valid), 32'd1);
      chk("s5_hold_pc", instr_pc, 32'hC);
      chk("s5_hold_req", 32'(imem_req), 32'd0);
    end
    @(posedge clock);
    #1 stall = 1'b0;
    @(negedge clock);
    chk("s5_consume_pc", instr_pc, 32'hC);
    next_addr(32'hC, a);
    chk("s5_next_addr", a, 32'h10);

    // Jump during HOLD drops the held instruction.
    wait_addr(32'h18);
    @(posedge clock);
    #1 stall = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #1 jump = 1'b1;
    jump_target = 32'h300;
    @(negedge clock);
    chk("s5_hold_drop", 32'(instr_valid), 32'd0);
    @(posedge clock);
    #1 jump = 1'b0;
    stall = 1'b0;
    next_valid(a);
    chk("s5_jump_pc", a, 32'h300);

    // PC wrap.
    do_reset(0);
    wait_addr(32'h4);
    @(posedge clock);
    #1 jump = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    @(negedge clock);
    chk("s6_wr_jump", 32'(pc_write), 32'd1);
    chk("s6_next_jump", pc_next, 32'hFFFF_FFFC);
    @(posedge clock);
    #1 jump = 1'b0;
    @(negedge clock);
    chk("s6_top_valid", 32'(instr_valid), 32'd1);
    chk("s6_top_pc", instr_pc, 32'hFFFF_FFFC);
    chk("s6_wrap_write", 32'(pc_write), 32'd1);
    chk("s6_wrap_next", pc_next, 32'h0);
    @(negedge clock);
    chk("s6_wrap_addr", imem_addr, 32'h0);

    // Asynchronous reset mid-wait.
    do_reset(5);
    wait_addr(32'h4);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("s7_req", 32'(imem_req), 32'd0);
    chk("s7_addr", imem_addr, 32'h0);
    chk("s7_valid", 32'(instr_valid), 32'd0);
    chk("s7_instr_pc", instr_pc, 32'h0);
    chk("s7_pc_write", 32'(pc_write), 32'd0);
    chk("s7_pc_next", pc_next, 32'h0);
    @(negedge clock);
    #1 reset = 1'b1;
    next_valid(a);
    chk("s7_restart_pc", a, 32'h0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required to end");
    $fatal(1);
  end

endmodule
